// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
// Execute-to-memory pipeline stage. Resolves conditional branches from the
// ALU flags at accept time and buffers results in a 2-entry skid buffer
// (main = head, skid = second) so that in_ready is a registered signal.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   flush               synchronous kill of all buffered entries
//   in_valid/in_ready   upstream handshake (in_ready registered)
//   alu_*               ALU result, flags and op code
//   is_branch, funct3,
//   branch_target       branch control and taken target
//   rd_addr, reg_write,
//   mem_read, mem_write,
//   store_data          instruction payload passed to the memory stage
//   out_valid/out_ready downstream handshake
//   out_*               head entry fields
//   redirect_valid/pc   PC redirect pulse for a popped taken branch
//   branch_err          sticky: branch issued with a non-SUB ALU op
// ---------------------------------------------------------------------------
module ex_mem_stage #(
   parameter int unsigned XLEN = 64,
   parameter int unsigned RA_W = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] alu_rd,
   input  logic            alu_zero,
   input  logic            alu_carry,
   input  logic            alu_overflow,
   input  logic [3:0]      alu_control,
   input  logic            is_branch,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] branch_target,
   input  logic [RA_W-1:0] rd_addr,
   input  logic            reg_write,
   input  logic            mem_read,
   input  logic            mem_write,
   input  logic [XLEN-1:0] store_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic [RA_W-1:0] out_rd_addr,
   output logic            out_reg_write,
   output logic            out_mem_read,
   output logic            out_mem_write,
   output logic [XLEN-1:0] out_store_data,
   output logic            out_branch_taken,
   output logic [XLEN-1:0] out_branch_target,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            branch_err
);

   localparam logic [3:0] ALU_SUB  = 4'b0110;

   localparam logic [1:0] ST_EMPTY = 2'b00;
   localparam logic [1:0] ST_ONE   = 2'b01;
   localparam logic [1:0] ST_FULL  = 2'b10;

   localparam logic [2:0] F3_BEQ   = 3'b000;
   localparam logic [2:0] F3_BNE   = 3'b001;
   localparam logic [2:0] F3_BLT   = 3'b100;
   localparam logic [2:0] F3_BGE   = 3'b101;
   localparam logic [2:0] F3_BLTU  = 3'b110;
   localparam logic [2:0] F3_BGEU  = 3'b111;

   typedef struct packed {
      logic [XLEN-1:0] result;
      logic [RA_W-1:0] rd_addr;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
      logic [XLEN-1:0] store_data;
      logic            taken;
      logic [XLEN-1:0] target;
   } entry_t;

   logic [1:0] state_q, state_d;
   entry_t     main_q, main_d;
   entry_t     skid_q, skid_d;
   entry_t     in_entry_c;
   logic       in_ready_q;
   logic       out_valid_q;
   logic       branch_err_q, branch_err_d;
   logic       accept_c;
   logic       pop_c;
   logic       sub_op_c;
   logic       cond_c;
   logic       taken_c;

   assign accept_c = in_valid & in_ready_q;
   assign pop_c    = out_valid_q & out_ready;
   assign sub_op_c = (alu_control == ALU_SUB);

   // Branch condition from ALU flags of rs1 - rs2
   always_comb begin
      cond_c = 1'b0;
      case (funct3)
         F3_BEQ:  cond_c = alu_zero;
         F3_BNE:  cond_c = ~alu_zero;
         F3_BLT:  cond_c = alu_rd[XLEN-1] ^ alu_overflow;
         F3_BGE:  cond_c = ~(alu_rd[XLEN-1] ^ alu_overflow);
         F3_BLTU: cond_c = alu_carry;
         F3_BGEU: cond_c = ~alu_carry;
         default: cond_c = 1'b0;
      endcase
      // Flags are only meaningful when the ALU performed a subtraction
      taken_c = is_branch & sub_op_c & cond_c;
   end

   // Incoming payload as it will be stored
   always_comb begin
      in_entry_c            = '0;
      in_entry_c.result     = alu_rd;
      in_entry_c.rd_addr    = rd_addr;
      in_entry_c.reg_write  = reg_write;
      in_entry_c.mem_read   = mem_read;
      in_entry_c.mem_write  = mem_write;
      in_entry_c.store_data = store_data;
      in_entry_c.taken      = taken_c;
      in_entry_c.target     = branch_target;
   end

   // State register and payload storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_EMPTY;
         main_q       <= '0;
         skid_q       <= '0;
         in_ready_q   <= 1'b1;
         out_valid_q  <= 1'b0;
         branch_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         main_q       <= main_d;
         skid_q       <= skid_d;
         in_ready_q   <= (state_d != ST_FULL);
         out_valid_q  <= (state_d != ST_EMPTY);
         branch_err_q <= branch_err_d;
      end
   end

   // Next-state and buffer update
   always_comb begin
      state_d      = state_q;
      main_d       = main_q;
      skid_d       = skid_q;
      branch_err_d = branch_err_q;

      if (flush) begin
         // Flush wins: any same-cycle accept is dropped
         state_d = ST_EMPTY;
      end else begin
         if (accept_c && is_branch && !sub_op_c) begin
            branch_err_d = 1'b1;
         end
         case (state_q)
            ST_EMPTY: begin
               if (accept_c) begin
                  main_d  = in_entry_c;
                  state_d = ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept_c && pop_c) begin
                  main_d  = in_entry_c;
                  state_d = ST_ONE;
               end else if (accept_c) begin
                  skid_d  = in_entry_c;
                  state_d = ST_FULL;
               end else if (pop_c) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (pop_c) begin
                  main_d  = skid_q;
                  state_d = ST_ONE;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   assign in_ready          = in_ready_q;
   assign out_valid         = out_valid_q;
   assign out_result        = main_q.result;
   assign out_rd_addr       = main_q.rd_addr;
   assign out_reg_write     = main_q.reg_write;
   assign out_mem_read      = main_q.mem_read;
   assign out_mem_write     = main_q.mem_write;
   assign out_store_data    = main_q.store_data;
   assign out_branch_taken  = main_q.taken;
   assign out_branch_target = main_q.target;
   assign branch_err        = branch_err_q;

   // Redirect fires on the pop of a taken head; a flush suppresses it
   assign redirect_valid    = pop_c & main_q.taken & ~flush;
   assign redirect_pc       = main_q.target;

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;

   localparam int unsigned XLEN = 64;
   localparam int unsigned RA_W = 5;

   logic            clk;
   logic            rst_n;
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] alu_rd;
   logic            alu_zero;
   logic            alu_carry;
   logic            alu_overflow;
   logic [3:0]      alu_control;
   logic            is_branch;
   logic [2:0]      funct3;
   logic [XLEN-1:0] branch_target;
   logic [RA_W-1:0] rd_addr;
   logic            reg_write;
   logic            mem_read;
   logic            mem_write;
   logic [XLEN-1:0] store_data;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_result;
   logic [RA_W-1:0] out_rd_addr;
   logic            out_reg_write;
   logic            out_mem_read;
   logic            out_mem_write;
   logic [XLEN-1:0] out_store_data;
   logic            out_branch_taken;
   logic [XLEN-1:0] out_branch_target;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;
   logic            branch_err;

   int checks;
   int errors;

   ex_mem_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .flush             (flush),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .alu_rd            (alu_rd),
      .alu_zero          (alu_zero),
      .alu_carry         (alu_carry),
      .alu_overflow      (alu_overflow),
      .alu_control       (alu_control),
      .is_branch         (is_branch),
      .funct3            (funct3),
      .branch_target     (branch_target),
      .rd_addr           (rd_addr),
      .reg_write         (reg_write),
      .mem_read          (mem_read),
      .mem_write         (mem_write),
      .store_data        (store_data),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_result        (out_result),
      .out_rd_addr       (out_rd_addr),
      .out_reg_write     (out_reg_write),
      .out_mem_read      (out_mem_read),
      .out_mem_write     (out_mem_write),
      .out_store_data    (out_store_data),
      .out_branch_taken  (out_branch_taken),
      .out_branch_target (out_branch_target),
      .redirect_valid    (redirect_valid),
      .redirect_pc       (redirect_pc),
      .branch_err        (branch_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: bench did not reach its end");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_alu(input logic v, input logic [63:0] rd_val, input logic [4:0] ra,
                          input logic br, input logic [2:0] f3, input logic [3:0] ctl,
                          input logic z, input logic c, input logic o);
      in_valid      = v;
      alu_rd        = rd_val;
      rd_addr       = ra;
      is_branch     = br;
      funct3        = f3;
      alu_control   = ctl;
      alu_zero      = z;
      alu_carry     = c;
      alu_overflow  = o;
      branch_target = br ? 64'h1000 : 64'h0;
      reg_write     = ~br;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      store_data    = rd_val ^ 64'hFFFF;
   endtask

   // Issue one branch, hold it, then pop it and check the redirect pulse
   task automatic do_branch(input string tag, input logic [2:0] f3, input logic [63:0] rd_val,
                            input logic z, input logic c, input logic o, input logic exp_taken);
      out_ready = 1'b0;
      set_alu(1'b1, rd_val, 5'd0, 1'b1, f3, 4'b0110, z, c, o);
      tick();
      in_valid = 1'b0;
      chk({tag, "_taken"}, 64'(out_branch_taken), 64'(exp_taken));
      chk({tag, "_held_redir"}, 64'(redirect_valid), 64'h0);
      out_ready = 1'b1;
      #1;
      chk({tag, "_redir"}, 64'(redirect_valid), 64'(exp_taken));
      if (exp_taken) chk({tag, "_redir_pc"}, redirect_pc, 64'h1000);
      tick();
      chk({tag, "_redir_once"}, 64'(redirect_valid), 64'h0);
      chk({tag, "_empty"}, 64'(out_valid), 64'h0);
      out_ready = 1'b0;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst_n     = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      set_alu(1'b0, 64'h0, 5'd0, 1'b0, 3'b000, 4'b0010, 1'b0, 1'b0, 1'b0);

      // Reset and idle
      #12;
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_in_ready", 64'(in_ready), 64'h1);
      chk("rst_redirect", 64'(redirect_valid), 64'h0);
      chk("rst_branch_err", 64'(branch_err), 64'h0);
      chk("rst_out_result", out_result, 64'h0);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_out_valid", 64'(out_valid), 64'h0);
         chk("idle_in_ready", 64'(in_ready), 64'h1);
      end

      // Streaming with 1-cycle latency
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         set_alu(1'b1, 64'(i), 5'(4 + i), 1'b0, 3'b000, 4'b0010, 1'b0, 1'b0, 1'b0);
         tick();
         chk("stream_result", out_result, 64'(i));
         chk("stream_rd", 64'(out_rd_addr), 64'(4 + i));
         chk("stream_in_ready", 64'(in_ready), 64'h1);
         chk("stream_store", out_store_data, 64'(i) ^ 64'hFFFF);
      end
      in_valid = 1'b0;
      tick();
      chk("stream_drain", 64'(out_valid), 64'h0);

      // Backpressure: A, B buffered, C held upstream
      out_ready = 1'b0;
      set_alu(1'b1, 64'hA, 5'd1, 1'b0, 3'b000, 4'b0010, 1'b0, 1'b0, 1'b0);
      tick();
      chk("bp_in_ready_one", 64'(in_ready), 64'h1);
      set_alu(1'b1, 64'hB, 5'd2, 1'b0, 3'b000, 4'b0010, 1'b0, 1'b0, 1'b0);
      tick();
      chk("bp_in_ready_full", 64'(in_ready), 64'h0);
      set_alu(1'b1, 64'hC, 5'd3, 1'b0, 3'b000, 4'b0010, 1'b0, 1'b0, 1'b0);
      tick();
      chk("bp_still_full", 64'(in_ready), 64'h0);
      chk("bp_head_a_stable", out_result, 64'hA);
      out_ready = 1'b1;
      #1;
      chk("bp_pop_a", out_result, 64'hA);
      tick();
      chk("bp_pop_b", out_result, 64'hB);
      chk("bp_valid_b", 64'(out_valid), 64'h1);
      chk("bp_in_ready_b", 64'(in_ready), 64'h1);
      tick();
      in_valid = 1'b0;
      chk("bp_pop_c", out_result, 64'hC);
      chk("bp_valid_c", 64'(out_valid), 64'h1);
      tick();
      chk("bp_no_dup", 64'(out_valid), 64'h0);

      // Branch resolution
      do_branch("beq", 3'b000, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1);
      do_branch("blt", 3'b100, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
      do_branch("bltu", 3'b110, 64'h5, 1'b0, 1'b1, 1'b0, 1'b1);
      do_branch("bgeu", 3'b111, 64'h5, 1'b0, 1'b1, 1'b0, 1'b0);
      do_branch("bne", 3'b001, 64'h5, 1'b0, 1'b0, 1'b0, 1'b1);

      // Flush while FULL with a taken branch at head
      out_ready = 1'b0;
      set_alu(1'b1, 64'h0, 5'd0, 1'b1, 3'b000, 4'b0110, 1'b1, 1'b0, 1'b0);
      tick();
      set_alu(1'b1, 64'h77, 5'd9, 1'b0, 3'b000, 4'b0010, 1'b0, 1'b0, 1'b0);
      tick();
      in_valid = 1'b0;
      chk("fl_full", 64'(in_ready), 64'h0);
      chk("fl_head_taken", 64'(out_branch_taken), 64'h1);
      flush     = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("fl_redir_suppressed", 64'(redirect_valid), 64'h0);
      tick();
      flush     = 1'b0;
      out_ready = 1'b0;
      chk("fl_out_valid", 64'(out_valid), 64'h0);
      chk("fl_in_ready", 64'(in_ready), 64'h1);
      chk("fl_no_redir", 64'(redirect_valid), 64'h0);

      // Accept in a flush cycle is discarded
      set_alu(1'b1, 64'h99, 5'd4, 1'b0, 3'b000, 4'b0010, 1'b0, 1'b0, 1'b0);
      flush = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("fl_discard", 64'(out_valid), 64'h0);

      // Branch with a non-SUB op: error, not taken, survives flush
      set_alu(1'b1, 64'h0, 5'd0, 1'b1, 3'b000, 4'b0010, 1'b1, 1'b0, 1'b0);
      tick();
      in_valid = 1'b0;
      chk("err_set", 64'(branch_err), 64'h1);
      chk("err_not_taken", 64'(out_branch_taken), 64'h0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("err_after_flush", 64'(branch_err), 64'h1);
      chk("err_flush_empty", 64'(out_valid), 64'h0);

      // Async reset mid-cycle
      set_alu(1'b1, 64'h55, 5'd7, 1'b0, 3'b000, 4'b0010, 1'b0, 1'b0, 1'b0);
      tick();
      in_valid = 1'b0;
      chk("ar_loaded", out_result, 64'h55);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_out_valid", 64'(out_valid), 64'h0);
      chk("ar_out_result", out_result, 64'h0);
      chk("ar_rd_addr", 64'(out_rd_addr), 64'h0);
      chk("ar_branch_err", 64'(branch_err), 64'h0);
      chk("ar_in_ready", 64'(in_ready), 64'h1);
      #3;
      rst_n = 1'b1;
      tick();
      chk("ar_post_idle", 64'(out_valid), 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
